// File: rtl/sm4_key_schedule.sv
// sm4_key_schedule
//   SM4 key expansion. The 128-bit master key is expanded into the 32 round
//   keys rk0..rk31. Each output beat carries UNROLL keys (1, 2 or 4).
//
//   Optional build macro: SM4_KEY_STORE_EN
//     defined   : every transferred round key is also written into a 32x32
//                 store that can be read back through rd_idx/rd_key, for
//                 example to walk the keys in reverse order for decryption.
//     undefined : no store; rd_key and key_cached are tied to 0.
//
//   Ports
//     clk        rising-edge clock
//     rst        synchronous active-high reset
//     start      begin expansion of key_in (sampled only in IDLE)
//     key_in     master key, MK0 = [127:96] .. MK3 = [31:0]
//     busy       high in every state except IDLE
//     rk_valid   rk_out/rk_index hold a beat
//     rk_ready   sink accepts the beat
//     rk_out     UNROLL round keys, lowest index in the MSBs
//     rk_index   index of the MSB key in rk_out
//     done       one-cycle pulse after the last beat transfers
//     rd_idx     stored-key read address
//     rd_key     stored key rk[rd_idx], one cycle after rd_idx
//     key_cached store holds a complete schedule
//     dbg_state  current FSM state (IDLE=0, LOAD=1, RUN=2, FIN=3)
//
//   Handshake: a beat moves on a rising edge where rk_valid & rk_ready are
//   both high. Once rk_valid is raised, rk_out and rk_index stay unchanged
//   until that transfer happens; the producer never withdraws a beat.

module sm4_key_schedule #(
  parameter int UNROLL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [127:0]          key_in,
  output logic                  busy,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic [32*UNROLL-1:0]  rk_out,
  output logic [4:0]            rk_index,
  output logic                  done,
  input  logic [4:0]            rd_idx,
  output logic [31:0]           rd_key,
  output logic                  key_cached,
  output logic [1:0]            dbg_state
);

  generate
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
      $error("sm4_key_schedule: UNROLL must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [31:0] FK0 = 32'hA3B1BAC6;
  localparam logic [31:0] FK1 = 32'h56AA3350;
  localparam logic [31:0] FK2 = 32'h677D9197;
  localparam logic [31:0] FK3 = 32'hB27022DC;

  localparam logic [4:0] STEP = 5'(UNROLL);
  localparam logic [4:0] LAST = 5'(32 - UNROLL);

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, FIN = 2'd3} state_t;

  state_t      state;
  logic [31:0] k_q [4];   // sliding window K(i)..K(i+3)

  // Byte j of CK_i is (4i+j)*7 mod 256 = 28i + 7j mod 256.
  function automatic logic [31:0] ck_word(input logic [7:0] i);
    logic [7:0] b;
    b = i * 8'd28;
    return {b, b + 8'd7, b + 8'd14, b + 8'd21};
  endfunction

  // Key-schedule round transform: byte-wise S-box, then L'.
  function automatic logic [31:0] t_prime(input logic [31:0] x);
    logic [31:0] b;
    b = {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  // Index of the first key of the beat being computed this cycle: 0 while
  // loading, otherwise the beat after the one currently presented.
  logic [4:0]            base_idx;
  logic [31:0]           w [UNROLL+4];
  logic [32*UNROLL-1:0]  beat;

  always_comb begin
    base_idx = (state == LOAD) ? 5'd0 : rk_index + STEP;
    for (int i = 0; i < 4; i++) w[i] = k_q[i];
    for (int u = 0; u < UNROLL; u++) begin
      w[u+4] = w[u] ^ t_prime(w[u+1] ^ w[u+2] ^ w[u+3] ^
                              ck_word({3'b000, base_idx} + 8'(u)));
    end
    beat = '0;
    for (int u = 0; u < UNROLL; u++) beat[32*(UNROLL-1-u) +: 32] = w[u+4];
  end

  logic xfer;
  assign xfer = rk_valid & rk_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      rk_out   <= '0;
      rk_index <= '0;
      for (int i = 0; i < 4; i++) k_q[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_q[0]   <= key_in[127:96] ^ FK0;
            k_q[1]   <= key_in[95:64]  ^ FK1;
            k_q[2]   <= key_in[63:32]  ^ FK2;
            k_q[3]   <= key_in[31:0]   ^ FK3;
            rk_index <= '0;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          rk_out   <= beat;
          rk_index <= '0;
          rk_valid <= 1'b1;
          for (int i = 0; i < 4; i++) k_q[i] <= w[UNROLL+i];
          state    <= RUN;
        end
        RUN: begin
          if (xfer) begin
            if (rk_index == LAST) begin
              rk_valid <= 1'b0;
              state    <= FIN;
            end else begin
              rk_out   <= beat;
              rk_index <= rk_index + STEP;
              for (int i = 0; i < 4; i++) k_q[i] <= w[UNROLL+i];
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

`ifdef SM4_KEY_STORE_EN
  logic [31:0] key_store [32];

  // Keys are captured as they leave, so the store only ever holds keys the
  // sink actually received. A reset mid-schedule leaves stale entries, but
  // key_cached stays low until a schedule completes.
  always_ff @(posedge clk) begin
    if (!rst && state == RUN && xfer) begin
      for (int u = 0; u < UNROLL; u++)
        key_store[rk_index + 5'(u)] <= rk_out[32*(UNROLL-1-u) +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key     <= '0;
      key_cached <= 1'b0;
    end else begin
      rd_key <= key_store[rd_idx];
      if (state == IDLE && start)
        key_cached <= 1'b0;
      else if (state == FIN)
        key_cached <= 1'b1;
    end
  end
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign rd_key        = '0;
  assign key_cached    = 1'b0;
`endif

endmodule
